// File: rtl/popcount_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : popcount_stream_if
// Brief    : Input-word and result handshakes of the popcount_stream engine.
// Revision : 1.0 - initial release
// ============================================================================
interface popcount_stream_if #(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_count;
    logic              out_overflow;

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_count, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/popcount_stream.sv
`default_nettype none
// ============================================================================
// Module   : popcount_stream
// Brief    : Chunked population count with per-word or saturating per-packet
//            totals, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_stream #(
    parameter int DATA_W  = 10,
    parameter int CHUNK_W = 4,
    parameter int ACC_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    popcount_stream_if.slave  bus
);
    localparam int c_NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int c_PAD_W  = c_NCHUNK * CHUNK_W;
    localparam int c_POS_W  = $clog2(CHUNK_W + 1);
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_COUNT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PAD_W-1:0] r_shift;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_last;
    logic               r_mode;
    logic [ACC_W-1:0]   r_total;
    logic               r_ovf;
    logic               r_emitted;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last_chunk;
    logic [c_PAD_W-1:0] w_padded;
    logic [CHUNK_W-1:0] w_chunk;
    logic [c_POS_W-1:0] w_pop;
    logic [ACC_W:0]     w_pop_ext;
    logic [ACC_W:0]     w_sum;

    assign w_in_ready   = (r_state == c_S_IDLE) && !rst;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_last_chunk = (r_idx == c_LAST_IDX);
    // The current chunk always sits at the bottom of the shift register.
    assign w_chunk      = r_shift[CHUNK_W-1:0];

    always_comb begin
        w_padded = '0;
        w_padded[DATA_W-1:0] = bus.in_data;
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < CHUNK_W; k++) begin
            w_pop = w_pop + c_POS_W'(w_chunk[k]);
        end
    end

    // One spare bit above the total exposes saturation as a carry-out.
    assign w_pop_ext = (ACC_W + 1)'(w_pop);
    assign w_sum     = {1'b0, r_total} + w_pop_ext;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_COUNT;
                end
            end
            c_S_COUNT: begin
                if (w_last_chunk) begin
                    w_state_nxt = (!r_mode || r_last) ? c_S_DONE : c_S_IDLE;
                end
            end
            c_S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_mode    <= 1'b0;
            r_total   <= '0;
            r_ovf     <= 1'b0;
            r_emitted <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= w_padded;
                        r_idx     <= '0;
                        r_last    <= bus.in_last;
                        r_mode    <= bus.mode;
                        r_emitted <= 1'b0;
                        // A per-word request or a fresh packet starts from zero.
                        if (!bus.mode || r_emitted) begin
                            r_total <= '0;
                            r_ovf   <= 1'b0;
                        end
                    end
                end
                c_S_COUNT: begin
                    r_shift <= r_shift >> CHUNK_W;
                    r_idx   <= r_idx + c_IDX_W'(1);
                    if (w_sum[ACC_W]) begin
                        r_total <= '1;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_total <= w_sum[ACC_W-1:0];
                    end
                end
                c_S_DONE: begin
                    if (bus.out_ready) begin
                        r_emitted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = (r_state == c_S_DONE);
    assign bus.out_count    = (r_state == c_S_DONE) ? r_total : '0;
    assign bus.out_overflow = (r_state == c_S_DONE) ? r_ovf : 1'b0;

endmodule
`default_nettype wire

// File: doc/popcount_stream.md
# popcount_stream

Sequential, parametrised population-count engine with valid/ready handshakes on both sides. It counts the set bits of each accepted DATA_W-bit word, CHUNK_W bits per clock. It either emits one count per word or accumulates a saturating total across a multi-word packet. It sits between a bit-vector producer and a consumer that needs per-word or per-packet set-bit totals, and replaces single-shot combinational counting where DATA_W is large or timing is tight.

## Interface
- DATA_W, 10, input word width (>=1)
- CHUNK_W, 4, bits counted per clock (1..DATA_W)
- ACC_W, 16, result/accumulator width; must be >= $clog2(DATA_W+1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word (high only in IDLE)
- in_data  in  DATA_W  word to count
- in_last  in  1  last word of packet (used only when mode=1)
- mode  in  1  0 = per-word result, 1 = packet accumulate; sampled with the word
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_count  out  ACC_W  set-bit count (word or packet total)
- out_overflow  out  1  packet total saturated

## Operation
- NCHUNK = ceil(DATA_W/CHUNK_W). The final chunk is zero-padded above bit DATA_W-1.
- FSM states: IDLE, COUNT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_data, in_last and mode, then go to COUNT with the chunk index at 0. Later input changes are ignored.
- Clear rule at acceptance: if mode=0, or if the previous result was emitted, the running total and sticky overflow are cleared before counting. If mode=0 is accepted while a mode=1 partial total is pending, the partial total is discarded.
- COUNT: each cycle, add the popcount of chunk i (bits i*CHUNK_W upward, LSB chunk first) to the total. The add saturates at 2^ACC_W-1; saturation sets the sticky overflow flag. Increment i. After chunk NCHUNK-1:
  - if mode=0 or in_last=1, go to DONE;
  - else go to IDLE, keeping the total (no output).
- DONE: out_valid=1, out_count=total, out_overflow=sticky flag. On out_ready, go to IDLE and mark the total as emitted.
- While out_valid=1 and out_ready=0, out_count and out_overflow hold stable.
- out_count is 0 when not in DONE.

## Timing
- Reset values: state IDLE, in_ready=1 from the first cycle after rst deasserts (0 while rst=1), out_valid=0, out_count=0, out_overflow=0, total=0, sticky=0.
- rst=1 in any state aborts the operation. The captured word and pending total are dropped, with no out_valid pulse.
- Latency: with the acceptance cycle as cycle 0, COUNT occupies cycles 1..NCHUNK and out_valid rises in cycle NCHUNK+1 (cycle 4 for the defaults).
- Throughput with out_ready=1:
  - emitting words: one per NCHUNK+2 cycles;
  - non-last packet words: one per NCHUNK+1 cycles.
- There is no input/output overlap. in_ready=0 throughout COUNT and DONE, including the DONE handshake cycle. in_ready returns in the following cycle.
- The per-chunk add uses POS_W = $clog2(CHUNK_W+1)-bit chunk counts, zero-extended to ACC_W+1 bits for the saturation check.

## Test plan
- Reset, then mode=0 with 10'h3FF and out_ready=1: out_valid=1 in cycle 4 with out_count=10, out_overflow=0; in_ready=1 in cycle 5.
- mode=0, back-to-back words 10'h000 then 10'h155 (in_valid held): counts 0 then 5. The second word is accepted in cycle 5 and its result appears in cycle 9.
- mode=1 packet 10'h3FF, 10'h001, 10'h3FF (in_last on the third): no out_valid for the first two words; a single result with out_count=21.
- Backpressure: out_ready=0 for 6 cycles in DONE. out_valid, out_count and out_overflow stay stable and in_ready=0. After the handshake, in_ready=1 in the next cycle.
- ACC_W=4, mode=1, two 10'h3FF words ending with last: out_count=15, out_overflow=1. The next mode=0 word 10'h001 gives out_count=1, out_overflow=0.
- Two abort/switch cases:
  - rst pulsed in COUNT cycle 2: out_valid is never asserted; a following mode=0 10'h00F yields 4.
  - a mode=0 word accepted after an unfinished mode=1 packet emits only its own count.
